// File: rtl/mux_scan_pkg.sv
// Purpose: shared constants, FSM state encoding and round-robin search for the mux select scanner.
// Latency: n/a (package only; next_rr is purely combinational).
// Backpressure: n/a.
package mux_scan_pkg;

  localparam int NUM_CH = 8;
  localparam int SEL_W  = 3;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    HOLD   = 2'd2
  } scan_state_t;

  // First set bit of req, searching upward from last+1 with wrap-around.
  // The SEL_W-bit add wraps mod NUM_CH, so i=NUM_CH revisits last itself.
  // With req==0 the result is last; callers qualify it with |req.
  function automatic logic [SEL_W-1:0] next_rr(input logic [NUM_CH-1:0] req,
                                                input logic [SEL_W-1:0]  last);
    logic [SEL_W-1:0] idx;
    logic             found;
    next_rr = last;
    found   = 1'b0;
    for (int i = 1; i <= NUM_CH; i++) begin
      idx = last + SEL_W'(i);
      if (!found && req[idx]) begin
        next_rr = idx;
        found   = 1'b1;
      end
    end
  endfunction

endpackage

// File: rtl/mux_sel_scanner_rr_pick.sv
// Purpose: combinational round-robin channel picker.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; the parent decides when the pick is used.
// Ports: req[7:0] requests, last[2:0] previously served channel,
//        pick[2:0] next channel after last, any = at least one request.
module rr_pick
  import mux_scan_pkg::*;
(
  input  logic [NUM_CH-1:0] req,
  input  logic [SEL_W-1:0]  last,
  output logic [SEL_W-1:0]  pick,
  output logic              any
);

  assign pick = next_rr(req, last);
  assign any  = |req;

endmodule

// File: rtl/mux_sel_scanner.sv
// Purpose: round-robin select sequencer for an 8:1 single-bit mux; drives s, waits dwell+1 cycles, samples din.
// Latency: sample presented dwell+2 cycles after the pick cycle; one sample per dwell+3 cycles with out_ready held high.
// Backpressure: out_valid/out_ch/out_data and s hold stable in HOLD until out_valid&&out_ready; no new pick meanwhile.
// Ports: clk, rst (sync, active-high), en, req[7:0], dwell[DWELL_W-1:0], din (mux output),
//        s[2:0] select, out_valid/out_ready handshake, out_ch[2:0], out_data.
// Optional feature macro: SCAN_PRIO0_EN (channel 0 strict priority; channels 1-7 round-robin among themselves).
module mux_sel_scanner
  import mux_scan_pkg::*;
#(
  parameter int DWELL_W = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic [NUM_CH-1:0]  req,
  input  logic [DWELL_W-1:0] dwell,
  input  logic               din,
  output logic [SEL_W-1:0]   s,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [SEL_W-1:0]   out_ch,
  output logic               out_data
);

  scan_state_t        state;
  logic [DWELL_W-1:0] cnt;
  logic [SEL_W-1:0]   last;

  logic [NUM_CH-1:0]  rr_req;
  logic [SEL_W-1:0]   rr_c;
  logic               rr_any;
  logic [SEL_W-1:0]   pick_c;
  logic               pick_any;

`ifdef SCAN_PRIO0_EN
  // Channel 0 is taken out of the rotation and overrides it when requesting.
  assign rr_req   = {req[NUM_CH-1:1], 1'b0};
  assign pick_c   = req[0] ? '0 : rr_c;
  assign pick_any = req[0] | rr_any;
`else
  assign rr_req   = req;
  assign pick_c   = rr_c;
  assign pick_any = rr_any;
`endif

  rr_pick u_rr_pick (
    .req  (rr_req),
    .last (last),
    .pick (rr_c),
    .any  (rr_any)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      s         <= '0;
      cnt       <= '0;
      last      <= SEL_W'(NUM_CH - 1);
      out_valid <= 1'b0;
      out_ch    <= '0;
      out_data  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          // en and req are only looked at here; once a channel is picked the
          // transaction runs to completion regardless of either.
          if (en && pick_any) begin
            s     <= pick_c;
            cnt   <= dwell;
            state <= SETTLE;
          end
        end
        SETTLE: begin
          if (cnt != '0) begin
            cnt <= cnt - 1'b1;
          end else begin
            out_data  <= din;
            out_ch    <= s;
            out_valid <= 1'b1;
            state     <= HOLD;
          end
        end
        HOLD: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
`ifdef SCAN_PRIO0_EN
            // A priority grant of channel 0 must not disturb the 1-7 rotation.
            if (out_ch != '0) last <= out_ch;
`else
            last <= out_ch;
`endif
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mux_sel_scanner.sv
// Purpose: directed self-checking bench for mux_sel_scanner with an expected-sample queue.
// Latency: n/a (testbench).
// Backpressure: exercises out_ready held low and held high.
module tb_mux_sel_scanner;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b0;
  logic [7:0] req = 8'h00;
  logic [3:0] dwell = 4'd0;
  logic       din;
  logic [2:0] s;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [2:0] out_ch;
  logic       out_data;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int last_hs = 0;

  typedef struct {
    logic [2:0] ch;
    logic       d;
    int         gap;
  } exp_t;

  exp_t sb[$];

  // The mux is modelled as input k carrying bit k[0].
  assign din = s[0];

  mux_sel_scanner #(.DWELL_W(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .req       (req),
    .dwell     (dwell),
    .din       (din),
    .s         (s),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_ch    (out_ch),
    .out_data  (out_data)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic push(input logic [2:0] ch, input int gap);
    exp_t e;
    e.ch  = ch;
    e.d   = ch[0];
    e.gap = gap;
    sb.push_back(e);
  endtask

  // Waits (bounded) for a negedge with out_valid&&out_ready, i.e. the cycle
  // whose rising edge completes the handshake, then checks the queue head.
  task automatic collect(input string tag);
    exp_t e;
    bit   got;
    got = 1'b0;
    for (int t = 0; t < 40 && !got; t++) begin
      @(negedge clk);
      if (out_valid && out_ready) got = 1'b1;
    end
    checks++;
    assert (got && sb.size() != 0) else begin
      errors++;
      $error("FAIL %s_handshake: observed valid=%0b queued=%0d expected handshake within 40 cycles",
             tag, got, sb.size());
    end
    if (got && sb.size() != 0) begin
      e = sb.pop_front();
      check({tag, "_ch"}, 32'(out_ch), 32'(e.ch));
      check({tag, "_data"}, 32'(out_data), 32'(e.d));
      if (e.gap != 0) check({tag, "_period"}, 32'(cyc - last_hs), 32'(e.gap));
      last_hs = cyc;
    end
  endtask

  task automatic do_reset(input int n);
    @(negedge clk);
    rst = 1'b1;
    repeat (n) @(negedge clk);
    rst = 1'b0;
    sb.delete();
  endtask

  initial begin
    bit seen_valid;

    // 1: reset values, then enabled with no requests -> nothing happens.
    en = 1'b1;
    req = 8'h00;
    do_reset(2);
    check("rst_s", 32'(s), 32'd0);
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_ch", 32'(out_ch), 32'd0);
    check("rst_data", 32'(out_data), 32'd0);
    seen_valid = 1'b0;
    out_ready = 1'b1;
    repeat (12) begin
      @(negedge clk);
      if (out_valid || s != 3'd0) seen_valid = 1'b1;
    end
    check("idle_no_pick", 32'(seen_valid), 32'd0);

    // 2: two requesters, dwell=0 -> alternate ch2/ch5, period 3.
    req = 8'b0010_0100;
    dwell = 4'd0;
    do_reset(1);
    push(3'd2, 0); push(3'd5, 3); push(3'd2, 3); push(3'd5, 3);
    repeat (4) collect("alt");

    // 3: all requesting, dwell=3 -> 0..7,0 with period 6.
    req = 8'hFF;
    dwell = 4'd3;
    do_reset(1);
    push(3'd0, 0);
    for (int k = 1; k <= 8; k++) push(3'(k), 6);
    repeat (9) collect("rr");

    // 4: single requester held off by out_ready=0 for 10 cycles.
    req = 8'h10;
    dwell = 4'd2;
    out_ready = 1'b0;
    do_reset(1);
    seen_valid = 1'b0;
    for (int t = 0; t < 20 && !seen_valid; t++) begin
      @(negedge clk);
      if (out_valid) seen_valid = 1'b1;
    end
    check("hold_valid_seen", 32'(seen_valid), 32'd1);
    repeat (10) begin
      @(negedge clk);
      check("hold_stable", {26'd0, out_valid, out_ch, out_data, s[0]}, {26'd0, 1'b1, 3'd4, 1'b0, 1'b0});
      check("hold_s", 32'(s), 32'd4);
    end
    push(3'd4, 0);
    @(posedge clk);
    #1 out_ready = 1'b1;
    collect("hold");

    // 5: reset in the middle of a long SETTLE.
    req = 8'hFF;
    dwell = 4'd0;
    do_reset(1);
    push(3'd0, 0);
    collect("pre_rst");
    dwell = 4'd15;
    repeat (4) @(negedge clk);
    check("settle_s", 32'(s), 32'd1);
    check("settle_valid", 32'(out_valid), 32'd0);
    rst = 1'b1;
    @(negedge clk);
    check("mid_rst", {28'd0, s, out_valid}, 32'd0);
    check("mid_rst_out", {28'd0, out_ch, out_data}, 32'd0);
    rst = 1'b0;
    dwell = 4'd0;
    push(3'd0, 0);
    collect("post_rst");

`ifdef SCAN_PRIO0_EN
    // 6: channel 0 priority, then 1/7 rotation once req[0] clears.
    req = 8'h83;
    dwell = 4'd0;
    do_reset(1);
    push(3'd0, 0); push(3'd0, 3); push(3'd0, 3);
    repeat (3) collect("prio0");
    req = 8'h82;
    push(3'd1, 3); push(3'd7, 3); push(3'd1, 3); push(3'd7, 3);
    repeat (4) collect("prio_rr");
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
